pe_fff_banked: RTL and testbench
================================

# pe_fff_banked

Output-stationary systolic PE with NUM_BANKS float accumulator banks, successor to the single-accumulator float PE. One bank accumulates products while another drains over the cOut/cIn shift chain in the same cycle, so array compute and result readout overlap. Tiles one grid position of the float GEMM array: operands flow east/south, results flow along the drain chain.

## Interface
- EXP_IN_A, 3: A operand exponent bits; A word is EXP_IN_A+FRAC_IN_A+1 bits (sign included).
- FRAC_IN_A, 2: A operand fraction bits.
- EXP_IN_B, 3: B operand exponent bits.
- FRAC_IN_B, 2: B operand fraction bits.
- TRAILING_BITS, 2: guard bits passed to the FMA.
- EXP_OUT, 5: accumulator exponent bits; accumulator word is EXP_OUT+FRAC_OUT+1 bits.
- FRAC_OUT, 8: accumulator fraction bits.
- OVERFLOW_DETECTION, 0: passed to the FMA.
- NUM_BANKS, 2: accumulator banks, 2..8. Elaboration error outside this range.
- ZERO_ON_SWAP, 1: 1 = the bank that becomes the compute bank on a swap is cleared to 0.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- aIn  in  W_A+1  A operand from the west.
- bIn  in  W_B+1  B operand from the north.
- aOut  out  W_A+1  registered A to the east.
- bOut  out  W_B+1  registered B to the south.
- enableMul  in  1  accumulate aIn*bIn into the compute bank, and forward operands.
- enableMulOut  out  1  registered enableMul, for wavefront chaining.
- enableShiftOut  in  1  shift the drain bank: load it with cIn.
- cIn  in  W_OUT+1  drain-chain input from the upstream PE.
- cOut  out  W_OUT+1  current value of the drain bank.
- bankSwap  in  1  advance the bank pointers.
- computeBank  out  clog2(NUM_BANKS)  index of the compute bank, for debug and bench.

## Operation
- Storage:
  - acc[0..NUM_BANKS-1], each W_OUT+1 bits.
  - Pointer cb: the compute bank.
  - Drain bank db = (cb+1) mod NUM_BANKS, which is the oldest bank.
- enableMul:
  - acc[cb] <= FMA(aIn, bIn, acc[cb]).
  - aOut <= aIn; bOut <= bIn.
- enableMul low: aOut, bOut and acc[cb] hold.
- enableShiftOut: acc[db] <= cIn.
- cOut = acc[db]. It is a mux over registers, with no arithmetic on the path.
- bankSwap:
  - cb <= (cb+1) mod NUM_BANKS, wrapping from NUM_BANKS-1 to 0.
  - The old db becomes the new cb.
  - If ZERO_ON_SWAP, acc[old db] <= 0.
- Simultaneous events (all legal):
  - enableMul with enableShiftOut: the two target different banks and both happen.
  - enableMul with bankSwap: the MAC updates the old cb; the swap takes effect for the next cycle.
  - enableShiftOut with bankSwap: the shift writes old db. If ZERO_ON_SWAP, the zero write wins.
- enableMulOut <= enableMul, every cycle (not gated).
- Reset:
  - All acc = 0; cb = 0; aOut = 0; bOut = 0; enableMulOut = 0.
  - Therefore cOut = 0 and computeBank = 0.
  - Reset mid-accumulation discards all banks. Reset has priority over every enable.

## Timing
- MAC latency 1: the FMA is combinational, and the result is visible in the bank (and on cOut once drained) the cycle after enableMul.
- aOut, bOut, enableMulOut: 1-cycle delay.
- Shift: cOut reflects cIn one cycle after enableShiftOut. A chain of K PEs drains in K cycles.
- Swap: computeBank and cOut change on the edge after bankSwap.
- No handshake. The controller guarantees that a bank is drained before it is swapped back into compute when ZERO_ON_SWAP=0.

## Structure
- Shared package pe_fff_pkg holds:
  - function bankIdxWidth(NUM_BANKS);
  - the NUM_BANKS_MIN/MAX constants.
- Sub-module: FloatMultiplyAddWithFloat (existing), one instance. Connections:
  - a = aIn, b = bIn;
  - accIn = acc[cb];
  - accOut feeds the acc[cb] write;
  - reset/clock passed through.
- Everything else (bank array, pointer, muxes) is inline.

## Test plan
All scenarios use default parameters.
- Reset, then three cycles of enableMul with a=1.0, b=2.0 -> acc[0]=6.0, cOut=0 (bank 1 drains), aOut=1.0, enableMulOut high.
- Then bankSwap -> computeBank=1, cOut=6.0, acc[1]=0.
- Shift with cIn=0.5 -> cOut=0.5 on the next cycle.
- Same cycle: enableMul (a=1.5, b=2.0) and enableShiftOut (cIn=3.0) -> compute bank +3.0 and cOut=3.0; no interference between banks.
- Same cycle: bankSwap and enableShiftOut (cIn=7.0), ZERO_ON_SWAP=1 -> the new compute bank reads 0, not 7.0.
- Same cycle: bankSwap and enableMul -> the product lands in the old bank.
- NUM_BANKS=3, four swaps -> computeBank sequence 1,2,0,1, and cOut always shows bank (cb+1)%3.
- Reset asserted mid-accumulation with enableMul high -> next cycle all outputs 0, computeBank=0.

Source files
------------

// File: rtl/pe_fff_pkg.sv
// pe_fff_pkg: shared constants and helpers for the banked float PE.
`default_nettype none

package pe_fff_pkg;

    localparam int NUM_BANKS_MIN = 2;
    localparam int NUM_BANKS_MAX = 8;

    // Width of a bank index; never below one bit so the pointer is a real vector.
    function automatic int bankIdxWidth(input int num_banks);
        return (num_banks <= 2) ? 1 : $clog2(num_banks);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pe_fff_banked_fma.sv
// FloatMultiplyAddWithFloat: combinational a*b + accIn on sign/exponent/fraction words.
// Zero exponent encodes zero (denormals flush), results truncate toward zero.
`default_nettype none

module FloatMultiplyAddWithFloat #(
    parameter int EXP_IN_A           = 3,
    parameter int FRAC_IN_A          = 2,
    parameter int EXP_IN_B           = 3,
    parameter int FRAC_IN_B          = 2,
    parameter int TRAILING_BITS      = 2,
    parameter int EXP_OUT            = 5,
    parameter int FRAC_OUT           = 8,
    parameter int OVERFLOW_DETECTION = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [EXP_IN_A+FRAC_IN_A:0] a,
    input  logic [EXP_IN_B+FRAC_IN_B:0] b,
    input  logic [EXP_OUT+FRAC_OUT:0]   accIn,
    output logic [EXP_OUT+FRAC_OUT:0]   accOut
);

    localparam int PW       = FRAC_IN_A + FRAC_IN_B + 2;
    localparam int NW       = ((PW > FRAC_OUT + 1) ? PW : FRAC_OUT + 1) + TRAILING_BITS;
    localparam int BIAS_A   = (1 << (EXP_IN_A - 1)) - 1;
    localparam int BIAS_B   = (1 << (EXP_IN_B - 1)) - 1;
    localparam int BIAS_OUT = (1 << (EXP_OUT - 1)) - 1;
    localparam int EXP_MAX  = (1 << EXP_OUT) - 1;
    localparam int ZERO_EXP = -100000;

    // Purely combinational; the clock/reset pins exist for drop-in compatibility.
    logic unused_ok;
    assign unused_ok = clock ^ reset;

    logic [PW-1:0] prod;
    logic [NW-1:0] p_man;
    logic [NW-1:0] c_man;
    logic [NW-1:0] big_man;
    logic [NW-1:0] small_man;
    logic [NW-1:0] small_sh;
    logic [NW:0]   sum;
    logic [NW:0]   norm;
    logic          p_sign;
    logic          big_sign;
    logic          small_sign;
    int            p_exp;
    int            c_exp;
    int            big_exp;
    int            small_exp;
    int            diff;
    int            lead;
    int            res_exp;

    always_comb begin
        prod   = PW'({1'b1, a[FRAC_IN_A-1:0]}) * PW'({1'b1, b[FRAC_IN_B-1:0]});
        p_sign = a[EXP_IN_A+FRAC_IN_A] ^ b[EXP_IN_B+FRAC_IN_B];
        p_exp  = int'(a[FRAC_IN_A +: EXP_IN_A]) + int'(b[FRAC_IN_B +: EXP_IN_B]) - BIAS_A - BIAS_B;
        if (prod[PW-1]) begin
            p_exp = p_exp + 1;
            p_man = NW'(prod) << (NW - PW);
        end else begin
            p_man = NW'(prod) << (NW - PW + 1);
        end
        if (a[FRAC_IN_A +: EXP_IN_A] == '0 || b[FRAC_IN_B +: EXP_IN_B] == '0) begin
            p_man = '0;
            p_exp = ZERO_EXP;
        end

        c_man = NW'({1'b1, accIn[FRAC_OUT-1:0]}) << (NW - FRAC_OUT - 1);
        c_exp = int'(accIn[FRAC_OUT +: EXP_OUT]) - BIAS_OUT;
        if (accIn[FRAC_OUT +: EXP_OUT] == '0) begin
            c_man = '0;
            c_exp = ZERO_EXP;
        end

        // Order by magnitude so an effective subtraction never goes negative.
        if (p_exp > c_exp || (p_exp == c_exp && p_man >= c_man)) begin
            big_man   = p_man;
            big_exp   = p_exp;
            big_sign  = p_sign;
            small_man = c_man;
            small_exp = c_exp;
            small_sign = accIn[EXP_OUT+FRAC_OUT];
        end else begin
            big_man   = c_man;
            big_exp   = c_exp;
            big_sign  = accIn[EXP_OUT+FRAC_OUT];
            small_man = p_man;
            small_exp = p_exp;
            small_sign = p_sign;
        end

        diff     = big_exp - small_exp;
        small_sh = (diff > NW) ? '0 : (small_man >> diff);
        if (big_sign == small_sign) begin
            sum = {1'b0, big_man} + {1'b0, small_sh};
        end else begin
            sum = {1'b0, big_man} - {1'b0, small_sh};
        end

        lead = -1;
        for (int i = 0; i <= NW; i++) begin
            if (sum[i]) begin
                lead = i;
            end
        end

        norm    = '0;
        res_exp = 0;
        accOut  = '0;
        if (lead >= 0) begin
            norm    = sum << (NW - lead);
            res_exp = big_exp + lead - (NW - 1) + BIAS_OUT;
            if (res_exp <= 0) begin
                accOut = '0;
            end else if (res_exp >= EXP_MAX) begin
                if (OVERFLOW_DETECTION != 0) begin
                    accOut = {big_sign, {EXP_OUT{1'b1}}, {FRAC_OUT{1'b0}}};
                end else begin
                    accOut = {big_sign, EXP_OUT'(EXP_MAX - 1), {FRAC_OUT{1'b1}}};
                end
            end else begin
                accOut = {big_sign, EXP_OUT'(res_exp), norm[NW-1 -: FRAC_OUT]};
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pe_fff_banked.sv
// pe_fff_banked: output-stationary float PE with NUM_BANKS accumulators; one bank
// computes while the oldest bank drains over the cIn/cOut chain.
`default_nettype none

module pe_fff_banked
    import pe_fff_pkg::*;
#(
    parameter int EXP_IN_A           = 3,
    parameter int FRAC_IN_A          = 2,
    parameter int EXP_IN_B           = 3,
    parameter int FRAC_IN_B          = 2,
    parameter int TRAILING_BITS      = 2,
    parameter int EXP_OUT            = 5,
    parameter int FRAC_OUT           = 8,
    parameter int OVERFLOW_DETECTION = 0,
    parameter int NUM_BANKS          = 2,
    parameter int ZERO_ON_SWAP       = 1,
    localparam int W_A   = EXP_IN_A + FRAC_IN_A,
    localparam int W_B   = EXP_IN_B + FRAC_IN_B,
    localparam int W_OUT = EXP_OUT + FRAC_OUT,
    localparam int BW    = bankIdxWidth(NUM_BANKS)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [W_A:0]   aIn,
    input  logic [W_B:0]   bIn,
    output logic [W_A:0]   aOut,
    output logic [W_B:0]   bOut,
    input  logic           enableMul,
    output logic           enableMulOut,
    input  logic           enableShiftOut,
    input  logic [W_OUT:0] cIn,
    output logic [W_OUT:0] cOut,
    input  logic           bankSwap,
    output logic [BW-1:0]  computeBank
);

    localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);

    if (NUM_BANKS < NUM_BANKS_MIN || NUM_BANKS > NUM_BANKS_MAX) begin : g_bad_num_banks
        $error("pe_fff_banked: NUM_BANKS must be within 2..8");
    end

    function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] idx);
        return (idx == LAST_BANK) ? '0 : idx + BW'(1);
    endfunction

    logic [W_OUT:0] acc_q [NUM_BANKS];
    logic [W_OUT:0] acc_d [NUM_BANKS];
    logic [BW-1:0]  cb_q;
    logic [BW-1:0]  cb_d;
    logic [W_A:0]   a_out_q;
    logic [W_A:0]   a_out_d;
    logic [W_B:0]   b_out_q;
    logic [W_B:0]   b_out_d;
    logic           enable_mul_out_q;
    logic           enable_mul_out_d;
    logic [BW-1:0]  db;
    logic [W_OUT:0] fma_out;

    // The drain bank is always the one right after the compute bank (the oldest).
    assign db = next_bank(cb_q);

    FloatMultiplyAddWithFloat #(
        .EXP_IN_A          (EXP_IN_A),
        .FRAC_IN_A         (FRAC_IN_A),
        .EXP_IN_B          (EXP_IN_B),
        .FRAC_IN_B         (FRAC_IN_B),
        .TRAILING_BITS     (TRAILING_BITS),
        .EXP_OUT           (EXP_OUT),
        .FRAC_OUT          (FRAC_OUT),
        .OVERFLOW_DETECTION(OVERFLOW_DETECTION)
    ) u_fma (
        .clock (clock),
        .reset (reset),
        .a     (aIn),
        .b     (bIn),
        .accIn (acc_q[cb_q]),
        .accOut(fma_out)
    );

    always_comb begin
        acc_d            = acc_q;
        cb_d             = cb_q;
        a_out_d          = a_out_q;
        b_out_d          = b_out_q;
        enable_mul_out_d = enableMul;
        if (enableMul) begin
            acc_d[cb_q] = fma_out;
            a_out_d     = aIn;
            b_out_d     = bIn;
        end
        if (enableShiftOut) begin
            acc_d[db] = cIn;
        end
        // Swap comes last so its clear overrides a same-cycle shift into the old drain bank.
        if (bankSwap) begin
            cb_d = db;
            if (ZERO_ON_SWAP != 0) begin
                acc_d[db] = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                acc_q[i] <= '0;
            end
            cb_q             <= '0;
            a_out_q          <= '0;
            b_out_q          <= '0;
            enable_mul_out_q <= 1'b0;
        end else begin
            acc_q            <= acc_d;
            cb_q             <= cb_d;
            a_out_q          <= a_out_d;
            b_out_q          <= b_out_d;
            enable_mul_out_q <= enable_mul_out_d;
        end
    end

    assign cOut         = acc_q[db];
    assign computeBank  = cb_q;
    assign aOut         = a_out_q;
    assign bOut         = b_out_q;
    assign enableMulOut = enable_mul_out_q;

endmodule

`default_nettype wire

// File: tb/tb_pe_fff_banked.sv
// tb_pe_fff_banked: directed checks of the banked float PE (2 banks, plus a 3-bank instance).
`default_nettype none

module tb_pe_fff_banked;

    // A/B words: s|eee|ff, bias 3.  Accumulator words: s|eeeee|ffffffff, bias 15.
    localparam logic [5:0]  A_1P0  = 6'h0C;
    localparam logic [5:0]  A_1P5  = 6'h0E;
    localparam logic [5:0]  B_2P0  = 6'h10;
    localparam logic [13:0] C_0P0  = 14'h0000;
    localparam logic [13:0] C_0P5  = 14'h0E00;
    localparam logic [13:0] C_2P0  = 14'h1000;
    localparam logic [13:0] C_3P0  = 14'h1080;
    localparam logic [13:0] C_6P0  = 14'h1180;
    localparam logic [13:0] C_7P0  = 14'h11C0;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  aIn, bIn, aOut, bOut;
    logic        enableMul, enableMulOut, enableShiftOut, bankSwap;
    logic [13:0] cIn, cOut;
    logic [0:0]  computeBank;

    logic [5:0]  a3, b3, a_out3, b_out3;
    logic        em3, em_out3, es3, sw3;
    logic [13:0] c_in3, c_out3;
    logic [1:0]  cb3;

    int n_tests  = 0;
    int n_failed = 0;

    always #5 clock = ~clock;

    pe_fff_banked dut (
        .clock         (clock),
        .reset         (reset),
        .aIn           (aIn),
        .bIn           (bIn),
        .aOut          (aOut),
        .bOut          (bOut),
        .enableMul     (enableMul),
        .enableMulOut  (enableMulOut),
        .enableShiftOut(enableShiftOut),
        .cIn           (cIn),
        .cOut          (cOut),
        .bankSwap      (bankSwap),
        .computeBank   (computeBank)
    );

    pe_fff_banked #(.NUM_BANKS(3), .ZERO_ON_SWAP(0)) dut3 (
        .clock         (clock),
        .reset         (reset),
        .aIn           (a3),
        .bIn           (b3),
        .aOut          (a_out3),
        .bOut          (b_out3),
        .enableMul     (em3),
        .enableMulOut  (em_out3),
        .enableShiftOut(es3),
        .cIn           (c_in3),
        .cOut          (c_out3),
        .bankSwap      (sw3),
        .computeBank   (cb3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        aIn = '0; bIn = '0; cIn = '0;
        enableMul = 1'b0; enableShiftOut = 1'b0; bankSwap = 1'b0;
        a3 = '0; b3 = '0; c_in3 = '0;
        em3 = 1'b0; es3 = 1'b0; sw3 = 1'b0;
        step();
        step();
        check("rst_aOut", 32'(aOut), 32'h0);
        check("rst_bOut", 32'(bOut), 32'h0);
        check("rst_cOut", 32'(cOut), 32'h0);
        check("rst_cb", 32'(computeBank), 32'h0);
        check("rst_emo", 32'(enableMulOut), 32'h0);

        // Three MACs of 1.0*2.0 into bank 0.
        reset = 1'b0;
        enableMul = 1'b1; aIn = A_1P0; bIn = B_2P0;
        step(); step(); step();
        check("mac_cOut_bank1", 32'(cOut), 32'(C_0P0));
        check("mac_aOut", 32'(aOut), 32'(A_1P0));
        check("mac_bOut", 32'(bOut), 32'(B_2P0));
        check("mac_emo", 32'(enableMulOut), 32'h1);
        check("mac_cb", 32'(computeBank), 32'h0);

        // Swap: bank 0 (6.0) becomes the drain bank.
        enableMul = 1'b0; bankSwap = 1'b1;
        step();
        check("swap_cb", 32'(computeBank), 32'h1);
        check("swap_cOut", 32'(cOut), 32'(C_6P0));
        check("swap_emo", 32'(enableMulOut), 32'h0);
        check("hold_aOut", 32'(aOut), 32'(A_1P0));

        bankSwap = 1'b0; enableShiftOut = 1'b1; cIn = C_0P5;
        step();
        check("shift_cOut", 32'(cOut), 32'(C_0P5));

        // MAC on bank 1 and shift into bank 0 in the same cycle.
        enableMul = 1'b1; aIn = A_1P5; bIn = B_2P0; cIn = C_3P0;
        step();
        check("mul_shift_cOut", 32'(cOut), 32'(C_3P0));
        check("mul_shift_aOut", 32'(aOut), 32'(A_1P5));
        check("mul_shift_cb", 32'(computeBank), 32'h1);

        // Swap with shift of 7.0: bank 0 is cleared; bank 1 (3.0) drains.
        enableMul = 1'b0; bankSwap = 1'b1; cIn = C_7P0;
        step();
        check("swap_shift_cb", 32'(computeBank), 32'h0);
        check("swap_shift_cOut", 32'(cOut), 32'(C_3P0));

        // Swap with MAC: 1.0*2.0 lands in bank 0, which must have been 0 (not 7.0).
        enableShiftOut = 1'b0; enableMul = 1'b1; aIn = A_1P0; bIn = B_2P0;
        step();
        check("swap_mac_cb", 32'(computeBank), 32'h1);
        check("swap_mac_cOut", 32'(cOut), 32'(C_2P0));

        // Bank 1 was cleared by that swap, so one MAC leaves exactly 2.0.
        bankSwap = 1'b0;
        step();
        enableMul = 1'b0; bankSwap = 1'b1;
        step();
        check("zero_swap_cb", 32'(computeBank), 32'h0);
        check("zero_swap_cOut", 32'(cOut), 32'(C_2P0));

        // Reset in the middle of accumulation.
        bankSwap = 1'b0; enableMul = 1'b1; aIn = A_1P5; bIn = B_2P0;
        step();
        reset = 1'b1;
        step();
        check("midrst_aOut", 32'(aOut), 32'h0);
        check("midrst_bOut", 32'(bOut), 32'h0);
        check("midrst_emo", 32'(enableMulOut), 32'h0);
        check("midrst_cOut", 32'(cOut), 32'h0);
        check("midrst_cb", 32'(computeBank), 32'h0);
        reset = 1'b0; enableMul = 1'b0;

        // Three-bank instance, no clear on swap.
        es3 = 1'b1; c_in3 = C_0P5; em3 = 1'b1; a3 = A_1P0; b3 = B_2P0;
        step();
        check("nb3_load_cOut", 32'(c_out3), 32'(C_0P5));
        check("nb3_load_cb", 32'(cb3), 32'h0);
        em3 = 1'b0; es3 = 1'b0; sw3 = 1'b1;
        step();
        check("nb3_swap1_cb", 32'(cb3), 32'h1);
        check("nb3_swap1_cOut", 32'(c_out3), 32'(C_0P0));
        sw3 = 1'b0; es3 = 1'b1; c_in3 = C_3P0;
        step();
        check("nb3_shift_cOut", 32'(c_out3), 32'(C_3P0));
        es3 = 1'b0; sw3 = 1'b1;
        step();
        check("nb3_swap2_cb", 32'(cb3), 32'h2);
        check("nb3_swap2_cOut", 32'(c_out3), 32'(C_2P0));
        step();
        check("nb3_swap3_cb", 32'(cb3), 32'h0);
        check("nb3_swap3_cOut", 32'(c_out3), 32'(C_0P5));
        step();
        check("nb3_swap4_cb", 32'(cb3), 32'h1);
        check("nb3_swap4_cOut", 32'(c_out3), 32'(C_3P0));
        sw3 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule

`default_nettype wire
